uart_rx: RTL and testbench

// - Serial UART receiver, 8N1, LSB first. Pairs with the processor's UART transmitter on the same baud setting.
// - Samples i_Rx_Serial at mid-bit, assembles one byte, and presents it with a one-clock valid pulse to the processor's load/DMA logic.
// - Flags framing errors (stop bit = 0) and rejects glitch start bits.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_if.sv | 27 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default bit timing and frame width.
// The transmitter imports the same package, so both ends agree on the encodings.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 87;
   localparam int DATA_BITS            = 8;

   typedef enum logic [2:0] {
      s_IDLE      = 3'd0,
      s_START     = 3'd1,
      s_DATA      = 3'd2,
      s_STOP      = 3'd3,
      s_CLEANUP   = 3'd4,
      s_WAIT_HIGH = 3'd5
   } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side signal bundle. The master modport is the receiver itself.
// The slave modport is whoever drives the serial line and consumes the bytes.
interface uart_rx_if;

   logic                           i_Rx_Serial;
   logic                           o_Rx_DV;
   logic [uart_pkg::DATA_BITS-1:0] o_Rx_Byte;
   logic                           o_Rx_Active;
   logic                           o_Rx_Frame_Err;

   modport master (
      input  i_Rx_Serial,
      output o_Rx_DV,
      output o_Rx_Byte,
      output o_Rx_Active,
      output o_Rx_Frame_Err
   );

   modport slave (
      output i_Rx_Serial,
      input  o_Rx_DV,
      input  o_Rx_Byte,
      input  o_Rx_Active,
      input  o_Rx_Frame_Err
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value.
// Idle-high lines such as UART RX reset to 1 so that leaving reset is not
// mistaken for a start bit.
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_Clock,
   input  logic             i_Rst_n,
   input  logic [WIDTH-1:0] i_Async,
   output logic [WIDTH-1:0] o_Sync
);

   logic [WIDTH-1:0] r_Meta;
   logic [WIDTH-1:0] r_Sync;

   // First flop may go metastable; the second gives it a full cycle to settle
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Meta <= RESET_VAL;
         r_Sync <= RESET_VAL;
      end else begin
         r_Meta <= i_Async;
         r_Sync <= r_Meta;
      end
   end

   assign o_Sync = r_Sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Finds the start bit edge, re-checks it at
// mid-bit to reject glitches, then samples every data bit and the stop bit at
// their centres. A good frame produces a one-clock o_Rx_DV pulse; a low stop bit
// produces a one-clock o_Rx_Frame_Err pulse instead, and o_Rx_Byte is left alone.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic     i_Clock,
   input  logic     i_Rst_n,
   uart_rx_if.master io_Rx
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
   localparam int IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] C_HALF     = CNT_W'(HALF);
   localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DATA_BITS - 1);

   uart_state_t          r_State;
   logic [CNT_W-1:0]     r_Clk_Count;
   logic [IDX_W-1:0]     r_Bit_Index;
   logic [DATA_BITS-1:0] r_Shift;
   logic [DATA_BITS-1:0] r_Byte;
   logic                 r_DV;
   logic                 r_Frame_Err;
   logic                 r_Active;

   uart_state_t          w_Next_State;
   logic [CNT_W-1:0]     w_Clk_Count;
   logic [IDX_W-1:0]     w_Bit_Index;
   logic [DATA_BITS-1:0] w_Shift;
   logic [DATA_BITS-1:0] w_Byte;
   logic                 w_DV;
   logic                 w_Frame_Err;
   logic                 w_Active;
   logic                 w_Rx;

   sync_2ff #(
      .WIDTH    (1),
      .RESET_VAL(1'b1)
   ) u_Rx_Sync (
      .i_Clock (i_Clock),
      .i_Rst_n (i_Rst_n),
      .i_Async (io_Rx.i_Rx_Serial),
      .o_Sync  (w_Rx)
   );

   // Register the whole receiver state; reset discards any partial frame
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_State     <= s_IDLE;
         r_Clk_Count <= '0;
         r_Bit_Index <= '0;
         r_Shift     <= '0;
         r_Byte      <= '0;
         r_DV        <= 1'b0;
         r_Frame_Err <= 1'b0;
         r_Active    <= 1'b0;
      end else begin
         r_State     <= w_Next_State;
         r_Clk_Count <= w_Clk_Count;
         r_Bit_Index <= w_Bit_Index;
         r_Shift     <= w_Shift;
         r_Byte      <= w_Byte;
         r_DV        <= w_DV;
         r_Frame_Err <= w_Frame_Err;
         r_Active    <= w_Active;
      end
   end

   // Next-state logic: bit timing, sampling, and the pulse outputs
   always_comb begin
      w_Next_State = r_State;
      w_Clk_Count  = r_Clk_Count;
      w_Bit_Index  = r_Bit_Index;
      w_Shift      = r_Shift;
      w_Byte       = r_Byte;
      w_DV         = 1'b0;
      w_Frame_Err  = 1'b0;
      w_Active     = r_Active;

      case (r_State)
         s_IDLE: begin
            w_Clk_Count = '0;
            w_Bit_Index = '0;
            w_Active    = 1'b0;
            if (!w_Rx) begin
               w_Next_State = s_START;
               w_Active     = 1'b1;
            end
         end

         s_START: begin
            if (r_Clk_Count == C_HALF) begin
               w_Clk_Count = '0;
               if (!w_Rx) begin
                  w_Next_State = s_DATA;
               end else begin
                  w_Next_State = s_IDLE;
                  w_Active     = 1'b0;
               end
            end else begin
               w_Clk_Count = r_Clk_Count + CNT_W'(1);
            end
         end

         s_DATA: begin
            if (r_Clk_Count == C_LAST) begin
               w_Clk_Count          = '0;
               w_Shift[r_Bit_Index] = w_Rx;
               if (r_Bit_Index == C_LAST_IDX) begin
                  w_Bit_Index  = '0;
                  w_Next_State = s_STOP;
               end else begin
                  w_Bit_Index = r_Bit_Index + IDX_W'(1);
               end
            end else begin
               w_Clk_Count = r_Clk_Count + CNT_W'(1);
            end
         end

         s_STOP: begin
            if (r_Clk_Count == C_LAST) begin
               w_Clk_Count = '0;
               if (w_Rx) begin
                  w_Byte = r_Shift;
                  w_DV   = 1'b1;
               end else begin
                  w_Frame_Err = 1'b1;
               end
               w_Active     = 1'b0;
               w_Next_State = s_CLEANUP;
            end else begin
               w_Clk_Count = r_Clk_Count + CNT_W'(1);
            end
         end

         s_CLEANUP: begin
            if (w_Rx) begin
               w_Next_State = s_IDLE;
            end else begin
               w_Next_State = s_WAIT_HIGH;
            end
         end

         s_WAIT_HIGH: begin
            if (w_Rx) begin
               w_Next_State = s_IDLE;
            end
         end

         default: begin
            w_Next_State = s_IDLE;
            w_Clk_Count  = '0;
            w_Bit_Index  = '0;
            w_Active     = 1'b0;
         end
      endcase
   end

   assign io_Rx.o_Rx_DV        = r_DV;
   assign io_Rx.o_Rx_Byte      = r_Byte;
   assign io_Rx.o_Rx_Active    = r_Active;
   assign io_Rx.o_Rx_Frame_Err = r_Frame_Err;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx. One receiver runs at 87 clocks/bit for the directed cases;
// a second at 8 clocks/bit receives all 256 byte values from a serial sender
// with random idle gaps. Each frame sent pushes its expected result into a
// queue, and a monitor per receiver pops and compares on every output pulse.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CPB      = 87;
   localparam int LCPB     = 8;
   localparam int LATENCY  = 829;
   localparam int FRAME_CK = 870;

   typedef struct {
      logic       isErr;
      logic [7:0] data;
   } expT;

   logic clk = 1'b0;
   logic rstMain_n;
   logic rstLoop_n;

   expT  mainQ[$];
   expT  loopQ[$];
   int   dvCycles[$];
   int   total        = 0;
   int   bad          = 0;
   int   cycleCount   = 0;
   int   lastFall     = 0;
   int   loopDvCount  = 0;
   int   loopErrCount = 0;

   uart_rx_if mainIf();
   uart_rx_if loopIf();

   uart_rx #(.CLKS_PER_BIT(CPB)) dutMain (
      .i_Clock (clk),
      .i_Rst_n (rstMain_n),
      .io_Rx   (mainIf)
   );

   uart_rx #(.CLKS_PER_BIT(LCPB)) dutLoop (
      .i_Clock (clk),
      .i_Rst_n (rstLoop_n),
      .io_Rx   (loopIf)
   );

   // Free-running clock and cycle counter for latency measurements
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount++;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic setLine(input int sel, input logic v);
      if (sel == 0) mainIf.i_Rx_Serial = v;
      else          loopIf.i_Rx_Serial = v;
   endtask

   // Drive the first nBits of a {stop,data,start} frame, LSB first, from a negedge
   task automatic driveBits(input int sel, input logic [9:0] frame, input int nBits);
      int cpb;
      cpb = (sel == 0) ? CPB : LCPB;
      for (int b = 0; b < nBits; b++) begin
         setLine(sel, frame[b]);
         repeat (cpb) @(negedge clk);
      end
   endtask

   // Send one full frame and record what the receiver must report for it
   task automatic applyStimulus(input int sel, input logic [7:0] data, input logic stopBit);
      expT e;
      e.isErr = ~stopBit;
      e.data  = data;
      if (sel == 0) mainQ.push_back(e);
      else          loopQ.push_back(e);
      lastFall = cycleCount + 1;
      driveBits(sel, {stopBit, data, 1'b0}, 10);
   endtask

   task automatic waitDrain(input int sel, input string tag);
      int n;
      int left;
      n    = 0;
      left = (sel == 0) ? mainQ.size() : loopQ.size();
      while (left != 0 && n < 5000) begin
         @(negedge clk);
         n++;
         left = (sel == 0) ? mainQ.size() : loopQ.size();
      end
      checkOutput(tag, left, 0);
   endtask

   // Scoreboard monitor for the 87 clocks/bit receiver
   always @(negedge clk) begin : monMain
      expT e;
      if (rstMain_n && (mainIf.o_Rx_DV || mainIf.o_Rx_Frame_Err)) begin
         checkOutput("main_exclusive", {31'b0, mainIf.o_Rx_DV & mainIf.o_Rx_Frame_Err}, 0);
         if (mainIf.o_Rx_DV) dvCycles.push_back(cycleCount);
         checkOutput("main_pending", {31'b0, mainQ.size() != 0}, 1);
         if (mainQ.size() != 0) begin
            e = mainQ.pop_front();
            checkOutput("main_kind_err", {31'b0, mainIf.o_Rx_Frame_Err}, {31'b0, e.isErr});
            if (!e.isErr) checkOutput("main_byte", {24'b0, mainIf.o_Rx_Byte}, {24'b0, e.data});
         end
      end
   end

   // Scoreboard monitor for the 8 clocks/bit loopback receiver
   always @(negedge clk) begin : monLoop
      expT e;
      if (rstLoop_n && (loopIf.o_Rx_DV || loopIf.o_Rx_Frame_Err)) begin
         if (loopIf.o_Rx_DV)        loopDvCount++;
         if (loopIf.o_Rx_Frame_Err) loopErrCount++;
         checkOutput("loop_pending", {31'b0, loopQ.size() != 0}, 1);
         if (loopQ.size() != 0) begin
            e = loopQ.pop_front();
            checkOutput("loop_kind_err", {31'b0, loopIf.o_Rx_Frame_Err}, {31'b0, e.isErr});
            if (!e.isErr) checkOutput("loop_byte", {24'b0, loopIf.o_Rx_Byte}, {24'b0, e.data});
         end
      end
   end

   // Directed sequence followed by the full-range loopback
   initial begin
      int gap;
      rstMain_n          = 1'b0;
      rstLoop_n          = 1'b0;
      mainIf.i_Rx_Serial = 1'b1;
      loopIf.i_Rx_Serial = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_dv",     {31'b0, mainIf.o_Rx_DV}, 0);
      checkOutput("reset_err",    {31'b0, mainIf.o_Rx_Frame_Err}, 0);
      checkOutput("reset_active", {31'b0, mainIf.o_Rx_Active}, 0);
      checkOutput("reset_byte",   {24'b0, mainIf.o_Rx_Byte}, 0);
      rstMain_n = 1'b1;
      rstLoop_n = 1'b1;
      repeat (10) @(negedge clk);

      // Single good byte and its latency from the falling edge
      dvCycles.delete();
      applyStimulus(0, 8'hA5, 1'b1);
      waitDrain(0, "a5_drain");
      checkOutput("a5_dv_count", dvCycles.size(), 1);
      if (dvCycles.size() > 0) checkOutput("a5_latency", dvCycles[0] - lastFall, LATENCY);
      checkOutput("a5_byte_held", {24'b0, mainIf.o_Rx_Byte}, 32'hA5);

      // Back-to-back frames with no idle gap
      repeat (CPB) @(negedge clk);
      dvCycles.delete();
      applyStimulus(0, 8'h00, 1'b1);
      applyStimulus(0, 8'hFF, 1'b1);
      applyStimulus(0, 8'h3C, 1'b1);
      waitDrain(0, "b2b_drain");
      checkOutput("b2b_dv_count", dvCycles.size(), 3);
      if (dvCycles.size() == 3) begin
         checkOutput("b2b_spacing_1", dvCycles[1] - dvCycles[0], FRAME_CK);
         checkOutput("b2b_spacing_2", dvCycles[2] - dvCycles[1], FRAME_CK);
      end

      // Glitch start bit: low for 20 clocks, rejected at the mid-bit check
      repeat (CPB) @(negedge clk);
      mainIf.i_Rx_Serial = 1'b0;
      repeat (20) @(negedge clk);
      mainIf.i_Rx_Serial = 1'b1;
      repeat (26) @(negedge clk);
      checkOutput("glitch_active_before_check", {31'b0, mainIf.o_Rx_Active}, 1);
      @(negedge clk);
      checkOutput("glitch_active_after_check", {31'b0, mainIf.o_Rx_Active}, 0);
      repeat (CPB) @(negedge clk);
      applyStimulus(0, 8'h55, 1'b1);
      waitDrain(0, "glitch_next_drain");
      checkOutput("glitch_next_byte", {24'b0, mainIf.o_Rx_Byte}, 32'h55);

      // Framing error followed by a stuck-low line, then a good byte
      repeat (CPB) @(negedge clk);
      applyStimulus(0, 8'h81, 1'b0);
      repeat (300) @(negedge clk);
      checkOutput("ferr_no_retrigger", {31'b0, mainIf.o_Rx_Active}, 0);
      checkOutput("ferr_byte_kept", {24'b0, mainIf.o_Rx_Byte}, 32'h55);
      waitDrain(0, "ferr_drain");
      mainIf.i_Rx_Serial = 1'b1;
      repeat (CPB) @(negedge clk);
      applyStimulus(0, 8'h42, 1'b1);
      waitDrain(0, "ferr_next_drain");
      checkOutput("ferr_next_byte", {24'b0, mainIf.o_Rx_Byte}, 32'h42);

      // Reset in the middle of bit 4 of 0xF0
      repeat (CPB) @(negedge clk);
      driveBits(0, {1'b1, 8'hF0, 1'b0}, 5);
      mainIf.i_Rx_Serial = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("rst_mid_active_before", {31'b0, mainIf.o_Rx_Active}, 1);
      rstMain_n = 1'b0;
      #1;
      checkOutput("rst_mid_active", {31'b0, mainIf.o_Rx_Active}, 0);
      checkOutput("rst_mid_byte",   {24'b0, mainIf.o_Rx_Byte}, 0);
      checkOutput("rst_mid_dv",     {31'b0, mainIf.o_Rx_DV}, 0);
      repeat (5) @(negedge clk);
      rstMain_n = 1'b1;
      repeat (CPB) @(negedge clk);
      applyStimulus(0, 8'h0F, 1'b1);
      waitDrain(0, "rst_next_drain");
      checkOutput("rst_next_byte", {24'b0, mainIf.o_Rx_Byte}, 32'h0F);

      // Loopback of every byte value with random idle gaps of 0..3 bits
      for (int v = 0; v < 256; v++) begin
         applyStimulus(1, 8'(v), 1'b1);
         gap = $urandom_range(0, 3);
         if (gap > 0) repeat (gap * LCPB) @(negedge clk);
      end
      waitDrain(1, "loop_drain");
      checkOutput("loop_dv_count",  loopDvCount, 256);
      checkOutput("loop_err_count", loopErrCount, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
